serial_tx_arbiter: RTL and testbench
====================================

# serial_tx_arbiter

Shares one serial transmit line among `NUM_REQ` requesters and frames each accepted 7-bit word for the team's serial receiver. Frame format: start bit 0, data bits 0..6 LSB first, one parity bit, then line held high. Arbitration is round-robin. Each requester uses a valid/ready handshake, so the block sits between the producer blocks and the physical `serial_out` wire.

## Interface
- `NUM_REQ`, 4 — number of requesters; range 2..8.
- `GAP_CYCLES`, 2 — high cycles driven after the parity bit before returning to IDLE; must be ≥1.

- `clk`  in  1  — sole clock; all logic on rising edge.
- `rstn`  in  1  — reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ  — per-requester word-available flag.
- `req_data`  in  NUM_REQ*7  — packed words; requester i drives bits [7i+6:7i].
- `req_ready`  out  NUM_REQ  — one-hot accept strobe; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `serial_out`  out  1  — registered serial line; idle level 1.
- `busy`  out  1  — high whenever state ≠ IDLE.
- `grant_id`  out  $clog2(NUM_REQ)  — index of the last accepted requester.
- `frame_done`  out  1  — one-cycle pulse in the first GAP cycle.

## Operation
- Reset values: `serial_out`=1, `req_ready`=0, `busy`=1 (FLUSH), `grant_id`=0, `frame_done`=0. The round-robin pointer is set to NUM_REQ-1, so requester 0 has top priority first.
- States: FLUSH → IDLE → START → DATA → PARITY → GAP → IDLE.
- FLUSH:
  - Entered from reset; lasts `FLUSH_CYCLES`=10 cycles with the line high.
  - Guarantees that a receiver cut off mid-frame drains to its idle state before any new start bit.
  - `req_ready`=0 throughout.
- IDLE:
  - `req_ready` is combinational: one-hot on the first asserted `req_valid` found searching from pointer+1 with wrap-around; all zero otherwise.
  - On handshake: latch the word, set `grant_id`, move the pointer to the winner, go to START.
- START: `serial_out`=0 for 1 cycle.
- DATA:
  - 7 cycles; `serial_out` = bit k of the latched word in cycle k.
  - 3-bit counter 0..6.
- PARITY:
  - 1 cycle; `serial_out` = XOR of the 7 data bits (even parity).
  - The receiver then reports parity OK (`parity_ok_n`=0).
- GAP: `GAP_CYCLES` cycles with `serial_out`=1; `frame_done` pulses in the first GAP cycle.
- Requester data is not used after the handshake; changes to `req_data` mid-frame have no effect.
- `req_valid` deasserting mid-frame has no effect on the current frame.
- Synchronous reset mid-frame: the next edge forces `serial_out`=1 and enters FLUSH. The partial frame is abandoned, and no `frame_done` is generated for it.

## Timing
- Handshake in cycle T:
  - `serial_out`=0 at T+1.
  - Data bits 0..6 at T+2..T+8.
  - Parity at T+9.
  - High at T+10..T+9+GAP_CYCLES.
  - IDLE at T+10+GAP_CYCLES.
- Earliest next handshake is T+10+GAP_CYCLES, so back-to-back frame period = 10+GAP_CYCLES cycles.
- Line high between parity and the next start bit ≥ GAP_CYCLES+1 cycles. This meets the receiver's one-cycle dead time after its last sample.
- `req_ready` goes high only in IDLE, combinationally the same cycle; `busy` rises on the cycle after the handshake.

## Structure
- Package `serial_pkg`:
  - `FRAME_DATA_BITS`=7, `FLUSH_CYCLES`=10.
  - State enum `tx_state_t` (FLUSH, IDLE, START, DATA, PARITY, GAP).
  - A parity function shared with the receiver-side code.
- Sub-module `rr_arbiter`:
  - Parameter NUM_REQ; inputs `req`, `ptr`; output one-hot `gnt` plus encoded index.
  - Purely combinational. The pointer register stays in the top module and updates only on handshake.

## Test plan
- Reset released, `req_valid`=4'b0001 from cycle 0 → `serial_out` high for 10 cycles; handshake at cycle 10; `busy` high through FLUSH.
- Requester 0 sends 7'h55 → line 0,1,0,1,0,1,0,1, parity 0, then 2 high cycles; `frame_done` one pulse; receiver model outputs `data_out`=7'h55, `parity_ok_n`=0.
- Requester 2 sends 7'h01 → parity bit 1; receiver yields 7'h01, `parity_ok_n`=0.
- `req_valid`=4'b1111 held, words 7'h10..7'h13 → grant order 0,1,2,3,0 with `grant_id` matching; frame period exactly 12 cycles; `req_ready` one-hot, only in IDLE.
- `rstn` pulsed low for 1 cycle during DATA bit 3 → `serial_out`=1 next cycle, 10 flush cycles, no `frame_done`; the next frame is received intact.
- GAP_CYCLES=1, single requester streaming 7'h7F, 7'h00 → both received correctly, parity 1 then 0; period 11 cycles.

Source files
------------

// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial transmit path and its matching receiver:
// frame geometry, transmitter state encoding and the frame parity helper.
// No ports (package).
// -----------------------------------------------------------------------------
package serial_pkg;

    localparam int FRAME_DATA_BITS = 7;
    localparam int FLUSH_CYCLES    = 10;

    typedef enum logic [2:0] {
        ST_FLUSH  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_GAP    = 3'd5
    } tx_state_t;

    // Even parity over one frame payload; the receiver uses the same helper.
    function automatic logic frame_parity(input logic [FRAME_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: returns the first asserted request
// found searching upward from ptr+1 with wrap-around.
// Ports:
//   req     in  NUM_REQ  request vector
//   ptr     in  IDX_W    index of the most recent winner
//   gnt     out NUM_REQ  one-hot grant (all zero when no request)
//   gnt_idx out IDX_W    encoded grant index (0 when no request)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic             found_s;
    logic [IDX_W-1:0] cand_s;

    // Scan candidates ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_s = IDX_W'((int'(ptr) + off) % NUM_REQ);
            if (!found_s && req[cand_s]) begin
                found_s      = 1'b1;
                gnt[cand_s]  = 1'b1;
                gnt_idx      = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// -----------------------------------------------------------------------------
// serial_tx_arbiter
// Round-robin shares one serial line among NUM_REQ valid/ready requesters and
// frames each accepted 7-bit word: start 0, data LSB first, even parity, then
// GAP_CYCLES high cycles. A FLUSH period after reset holds the line high long
// enough for a receiver cut off mid-frame to drain.
// Ports:
//   clk        in  1             rising-edge clock
//   rstn       in  1             synchronous active-low reset
//   req_valid  in  NUM_REQ       per-requester word available
//   req_data   in  NUM_REQ*7     packed words, requester i at [7i+6:7i]
//   req_ready  out NUM_REQ       one-hot accept strobe, combinational in IDLE
//   serial_out out 1             registered serial line, idles high
//   busy       out 1             high whenever not IDLE
//   grant_id   out clog2(NUM_REQ) index of the last accepted requester
//   frame_done out 1             pulse in the first gap cycle
// -----------------------------------------------------------------------------
module serial_tx_arbiter
    import serial_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*FRAME_DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic                               serial_out,
    output logic                               busy,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
    output logic                               frame_done
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (FLUSH_CYCLES > GAP_CYCLES) ? FLUSH_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    tx_state_t                  state_r, state_nxt_s;
    logic                       serial_out_r, serial_nxt_s;
    logic                       busy_r;
    logic                       frame_done_r, frame_done_nxt_s;
    logic [IDX_W-1:0]           grant_id_r, grant_nxt_s;
    logic [IDX_W-1:0]           ptr_r, ptr_nxt_s;
    logic [FRAME_DATA_BITS-1:0] word_r, word_nxt_s;
    logic [2:0]                 bit_cnt_r, bit_cnt_nxt_s;
    logic [CNT_W-1:0]           cyc_cnt_r, cyc_cnt_nxt_s;
    logic [NUM_REQ-1:0]         gnt_s;
    logic [IDX_W-1:0]           gnt_idx_s;
    logic                       handshake_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    assign req_ready   = (state_r == ST_IDLE) ? gnt_s : '0;
    assign handshake_s = |(req_valid & req_ready);
    assign serial_out  = serial_out_r;
    assign busy        = busy_r;
    assign grant_id    = grant_id_r;
    assign frame_done  = frame_done_r;

    // Next-state logic; serial_nxt_s is the line level for the cycle after
    // this edge, so the registered line lines up with the state it enters.
    always_comb begin
        state_nxt_s      = state_r;
        serial_nxt_s     = 1'b1;
        frame_done_nxt_s = 1'b0;
        grant_nxt_s      = grant_id_r;
        ptr_nxt_s        = ptr_r;
        word_nxt_s       = word_r;
        bit_cnt_nxt_s    = bit_cnt_r;
        cyc_cnt_nxt_s    = cyc_cnt_r;
        case (state_r)
            ST_FLUSH: begin
                if (cyc_cnt_r == CNT_W'(FLUSH_CYCLES - 1)) begin
                    state_nxt_s   = ST_IDLE;
                    cyc_cnt_nxt_s = '0;
                end else begin
                    cyc_cnt_nxt_s = cyc_cnt_r + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (handshake_s) begin
                    state_nxt_s  = ST_START;
                    serial_nxt_s = 1'b0;
                    word_nxt_s   = req_data[int'(gnt_idx_s)*FRAME_DATA_BITS +: FRAME_DATA_BITS];
                    grant_nxt_s  = gnt_idx_s;
                    ptr_nxt_s    = gnt_idx_s;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_START: begin
                state_nxt_s   = ST_DATA;
                bit_cnt_nxt_s = 3'd0;
                serial_nxt_s  = word_r[0];
            end
            ST_DATA: begin
                if (bit_cnt_r == 3'(FRAME_DATA_BITS - 1)) begin
                    state_nxt_s  = ST_PARITY;
                    serial_nxt_s = frame_parity(word_r);
                end else begin
                    bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                    serial_nxt_s  = word_r[bit_cnt_r + 3'd1];
                end
            end
            ST_PARITY: begin
                state_nxt_s      = ST_GAP;
                frame_done_nxt_s = 1'b1;
                cyc_cnt_nxt_s    = '0;
            end
            ST_GAP: begin
                if (cyc_cnt_r == CNT_W'(GAP_CYCLES - 1)) begin
                    state_nxt_s   = ST_IDLE;
                    cyc_cnt_nxt_s = '0;
                end else begin
                    cyc_cnt_nxt_s = cyc_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s   = ST_FLUSH;
                cyc_cnt_nxt_s = '0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame and re-enters FLUSH.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r      <= ST_FLUSH;
            serial_out_r <= 1'b1;
            busy_r       <= 1'b1;
            frame_done_r <= 1'b0;
            grant_id_r   <= '0;
            ptr_r        <= IDX_W'(NUM_REQ - 1);
            word_r       <= '0;
            bit_cnt_r    <= 3'd0;
            cyc_cnt_r    <= '0;
        end else begin
            state_r      <= state_nxt_s;
            serial_out_r <= serial_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
            frame_done_r <= frame_done_nxt_s;
            grant_id_r   <= grant_nxt_s;
            ptr_r        <= ptr_nxt_s;
            word_r       <= word_nxt_s;
            bit_cnt_r    <= bit_cnt_nxt_s;
            cyc_cnt_r    <= cyc_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_arbiter
// Drives serial_tx_arbiter (GAP_CYCLES=2 as dut, GAP_CYCLES=1 as dut1) and
// compares every cycle against a queue-based model of the framing rules plus
// a sampling receiver model.
// -----------------------------------------------------------------------------
module tb_serial_tx_arbiter;

    localparam int NR  = 4;
    localparam int GAP = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    logic [NR-1:0]   req_valid, req_ready;
    logic [NR*7-1:0] req_data;
    logic            serial_out, busy, frame_done;
    logic [1:0]      grant_id;

    logic [NR-1:0]   req_valid1, req_ready1;
    logic [NR*7-1:0] req_data1;
    logic            serial_out1, busy1, frame_done1;
    logic [1:0]      grant_id1;

    serial_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .serial_out(serial_out), .busy(busy),
        .grant_id(grant_id), .frame_done(frame_done)
    );

    serial_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(1)) dut1 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid1), .req_data(req_data1),
        .req_ready(req_ready1), .serial_out(serial_out1), .busy(busy1),
        .grant_id(grant_id1), .frame_done(frame_done1)
    );

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    // Reference model: expected line levels / done pulses for future cycles.
    int   flush_left;
    int   ptr_m;
    int   grant_m;
    bit   line_q[$];
    bit   done_q[$];
    int   hs_cycle[$];
    int   hs_who[$];
    logic [6:0] sent_q[$];
    int   fd_count = 0;

    // Receiver model.
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;
    bit         rx_discard = 1'b0;
    int         rx_frames = 0;
    logic [6:0] rx_data_out = 7'h00;
    logic       rx_parity_ok_n = 1'b0;

    // Logs.
    logic line_log0 [0:2047];
    logic line_log1 [0:2047];
    int   hs1_cycle[$];
    int   fd1_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int p);
        for (int k = 1; k <= NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        flush_left = 10;
        ptr_m      = NR - 1;
        grant_m    = 0;
        line_q.delete();
        done_q.delete();
        sent_q.delete();
    endtask

    task automatic step();
        bit            idle_m;
        bit            hs;
        int            win;
        logic [NR-1:0] exp_ready;
        logic [6:0]    w;
        @(negedge clk);
        idle_m    = (flush_left == 0) && (line_q.size() == 0);
        win       = idle_m ? rr_pick(req_valid, ptr_m) : -1;
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        chk("serial_out", 32'(serial_out), (line_q.size() != 0) ? 32'(line_q[0]) : 32'd1);
        chk("busy", 32'(busy), 32'(!idle_m));
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("grant_id", 32'(grant_id), 32'(grant_m));
        chk("frame_done", 32'(frame_done), (done_q.size() != 0) ? 32'(done_q[0]) : 32'd0);
        if (frame_done === 1'b1) fd_count++;
        if (frame_done1 === 1'b1) fd1_count++;
        if (cycle < 2048) begin
            line_log0[cycle] = serial_out;
            line_log1[cycle] = serial_out1;
        end
        if ((req_valid1 & req_ready1) != '0 && rstn) hs1_cycle.push_back(cycle);
        // receiver: start bit, 7 data bits, parity bit
        if (rx_cnt == 0) begin
            if (serial_out === 1'b0) rx_cnt = 1;
        end else begin
            rx_sh[rx_cnt-1] = serial_out;
            if (rx_cnt == 8) begin
                rx_cnt         = 0;
                rx_data_out    = rx_sh[6:0];
                rx_parity_ok_n = ((^rx_sh[6:0]) != rx_sh[7]);
                if (rx_discard) begin
                    rx_discard = 1'b0;
                end else begin
                    rx_frames++;
                    chk("rx_parity_ok_n", 32'(rx_parity_ok_n), 32'd0);
                    chk("rx_pending", 32'(sent_q.size() != 0), 32'd1);
                    if (sent_q.size() != 0) chk("rx_data", 32'(rx_data_out), 32'(sent_q.pop_front()));
                end
            end else begin
                rx_cnt++;
            end
        end
        hs = idle_m && (win >= 0) && (rstn === 1'b1);
        w  = (win >= 0) ? req_data[win*7 +: 7] : 7'h00;
        @(posedge clk);
        if (rstn !== 1'b1) begin
            model_reset();
            if (rx_cnt != 0) rx_discard = 1'b1;
        end else begin
            if (line_q.size() != 0) begin
                void'(line_q.pop_front());
                void'(done_q.pop_front());
            end else if (flush_left > 0) begin
                flush_left--;
            end
            if (hs) begin
                line_q.push_back(1'b0); done_q.push_back(1'b0);
                for (int k = 0; k < 7; k++) begin
                    line_q.push_back(w[k]); done_q.push_back(1'b0);
                end
                line_q.push_back(^w); done_q.push_back(1'b0);
                for (int g = 0; g < GAP; g++) begin
                    line_q.push_back(1'b1); done_q.push_back(g == 0);
                end
                ptr_m   = win;
                grant_m = win;
                hs_cycle.push_back(cycle);
                hs_who.push_back(win);
                sent_q.push_back(w);
            end
        end
        cycle++;
        #1;
    endtask

    task automatic step_until_hs(input int bound, input string tag);
        int n0;
        int k;
        n0 = hs_cycle.size();
        k  = 0;
        while (hs_cycle.size() == n0 && k < bound) begin
            step();
            k++;
        end
        chk({tag, "_hs_seen"}, 32'(hs_cycle.size() > n0), 32'd1);
    endtask

    initial begin
        bit   exp55 [11] = '{0,1,0,1,0,1,0,1,0,1,1};
        bit   exp01 [11] = '{0,1,0,0,0,0,0,0,1,1,1};
        bit   exp7f [10] = '{0,1,1,1,1,1,1,1,1,1};
        bit   exp00 [10] = '{0,0,0,0,0,0,0,0,0,1};
        int   order [5]  = '{0,1,2,3,0};
        int   h, n0, rst_c, fd0, rx0, h0;

        rstn       = 1'b0;
        req_valid  = 4'b0001;
        req_data   = '0;
        req_data[6:0] = 7'h55;
        req_valid1 = 4'b0000;
        req_data1  = '0;
        repeat (2) @(posedge clk);
        model_reset();
        #1 rstn = 1'b1;

        // Test 1: flush then requester 0 sends 0x55
        step_until_hs(30, "t1");
        req_valid = 4'b0000;
        if (hs_cycle.size() >= 1) begin
            h = hs_cycle[0];
            chk("t1_hs_cycle", 32'(h), 32'd10);
            repeat (12) step();
            for (int k = 0; k < 11; k++) chk("t1_line", 32'(line_log0[h+1+k]), 32'(exp55[k]));
            chk("t1_rx_data", 32'(rx_data_out), 32'h55);
            chk("t1_done_count", 32'(fd_count), 32'd1);
        end

        // Test 2: requester 2 sends 0x01
        req_valid = 4'b0100;
        req_data[20:14] = 7'h01;
        step_until_hs(30, "t2");
        req_valid = 4'b0000;
        h = hs_cycle[hs_cycle.size()-1];
        repeat (12) step();
        for (int k = 0; k < 11; k++) chk("t2_line", 32'(line_log0[h+1+k]), 32'(exp01[k]));
        chk("t2_rx_data", 32'(rx_data_out), 32'h01);
        chk("t2_grant", 32'(grant_id), 32'd2);

        // Test 3: all requesting after reset, words 0x10..0x13
        req_valid = 4'b1111;
        req_data  = {7'h13, 7'h12, 7'h11, 7'h10};
        rstn = 1'b0;
        step();
        rstn  = 1'b1;
        rst_c = cycle;
        n0    = hs_cycle.size();
        for (int j = 0; j < 5; j++) step_until_hs(30, "t3");
        req_valid = 4'b0000;
        repeat (14) step();
        if (hs_cycle.size() == n0 + 5) begin
            chk("t3_first_hs", 32'(hs_cycle[n0] - rst_c), 32'd10);
            for (int j = 0; j < 5; j++) chk("t3_order", 32'(hs_who[n0+j]), 32'(order[j]));
            for (int j = 1; j < 5; j++) chk("t3_period", 32'(hs_cycle[n0+j] - hs_cycle[n0+j-1]), 32'd12);
        end

        // Test 4: reset during data bit 3 abandons the frame
        req_valid = 4'b0010;
        req_data[13:7] = 7'h2A;
        step_until_hs(30, "t4a");
        req_valid = 4'b0000;
        repeat (4) step();
        fd0  = fd_count;
        rx0  = rx_frames;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("t4_line_high_after_rst", 32'(serial_out), 32'd1);
        repeat (12) step();
        chk("t4_no_done", 32'(fd_count - fd0), 32'd0);
        chk("t4_no_rx", 32'(rx_frames - rx0), 32'd0);
        req_valid = 4'b0010;
        req_data[13:7] = 7'h4C;
        step_until_hs(30, "t4b");
        req_valid = 4'b0000;
        repeat (14) step();
        chk("t4_next_rx", 32'(rx_frames - rx0), 32'd1);
        chk("t4_next_data", 32'(rx_data_out), 32'h4C);

        // Test 5: random valid/data every cycle, checked by the model
        rx0 = rx_frames;
        h0  = hs_cycle.size();
        for (int i = 0; i < 300; i++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_data  = 28'($urandom);
            step();
        end
        req_valid = 4'b0000;
        repeat (15) step();
        chk("t5_rx_count", 32'(rx_frames - rx0), 32'(hs_cycle.size() - h0));

        // Test 6: GAP_CYCLES=1 instance streams 0x7F then 0x00
        hs1_cycle.delete();
        fd1_count = 0;
        req_valid1 = 4'b0001;
        req_data1[6:0] = 7'h7F;
        for (int i = 0; i < 40 && hs1_cycle.size() < 2; i++) begin
            step();
            if (hs1_cycle.size() == 1) req_data1[6:0] = 7'h00;
        end
        req_valid1 = 4'b0000;
        repeat (12) step();
        chk("t6_hs_count", 32'(hs1_cycle.size()), 32'd2);
        if (hs1_cycle.size() == 2) begin
            chk("t6_period", 32'(hs1_cycle[1] - hs1_cycle[0]), 32'd11);
            for (int k = 0; k < 10; k++) chk("t6_line7f", 32'(line_log1[hs1_cycle[0]+1+k]), 32'(exp7f[k]));
            for (int k = 0; k < 10; k++) chk("t6_line00", 32'(line_log1[hs1_cycle[1]+1+k]), 32'(exp00[k]));
        end
        chk("t6_done_count", 32'(fd1_count), 32'd2);
        chk("t6_idle", 32'(busy1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
